// File: rtl/twi_pkg.sv
// Shared types and helpers for the registered twiddle-bank mux (twi_bank_mux_pipe).
package twi_pkg;

  localparam int TWI_P_WIDTH  = 64;
  localparam int TWI_RADIX    = 16;
  localparam int TWI_NUM_BANK = 2;

  typedef logic [TWI_P_WIDTH-1:0] twi_word_t;

  // Occupancy of the single output register.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } twi_state_t;

  // Bit offset of bank b, lane r inside the flattened bank_data bus.
  function automatic int lane_off(input int bank, input int lane, input int radix,
                                  input int p_width);
    return (bank * radix + lane) * p_width;
  endfunction

endpackage

// File: rtl/twi_lane_sel.sv
// Combinational NUM_BANK:1 select of one twiddle lane; unknown banks fall back to bank 0.
module twi_lane_sel
  import twi_pkg::*;
#(
  parameter int P_WIDTH  = TWI_P_WIDTH,
  parameter int NUM_BANK = TWI_NUM_BANK,
  parameter int BSEL_W   = $clog2(NUM_BANK)
) (
  input  logic [NUM_BANK*P_WIDTH-1:0] lane_bus,
  input  logic [BSEL_W-1:0]           bank_sel,
  output logic [P_WIDTH-1:0]          lane_data
);

  always_comb begin
    // NOTE: assigning a default before any conditional keeps this block free of latches.
    lane_data = lane_bus[P_WIDTH-1:0];
    for (int b = 1; b < NUM_BANK; b++) begin
      if (bank_sel == BSEL_W'(b)) lane_data = lane_bus[b*P_WIDTH +: P_WIDTH];
    end
  end

endmodule

// File: rtl/twi_bank_mux_pipe.sv
// Registered twiddle-bank mux with valid/ready output stage, select-error flag and transfer count.
// Optional build macro TWI_LANE0_ONE_EN forces lane 0 to the constant 1 (w^0).
module twi_bank_mux_pipe
  import twi_pkg::*;
#(
  parameter int P_WIDTH  = TWI_P_WIDTH,
  parameter int RADIX    = TWI_RADIX,
  parameter int NUM_BANK = TWI_NUM_BANK,
  parameter int BSEL_W   = $clog2(NUM_BANK),
  parameter int CNT_W    = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [BSEL_W-1:0]                   bank_sel,
  input  logic [NUM_BANK*RADIX*P_WIDTH-1:0]   bank_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [RADIX*P_WIDTH-1:0]            twi_data,
  output logic [BSEL_W-1:0]                   twi_bank,
  output logic                                sel_err,
  output logic [CNT_W-1:0]                    xfer_cnt,
  input  logic                                clr
);

  twi_state_t                 state_q, state_d;
  logic                       load, xfer, sel_oor;
  logic [BSEL_W-1:0]          eff_bank;
  logic [RADIX*P_WIDTH-1:0]   sel_data;

  assign out_valid = (state_q == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign load      = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;

  // Only reachable when NUM_BANK is not a power of two.
  assign sel_oor  = ({1'b0, bank_sel} >= (BSEL_W+1)'(NUM_BANK));
  assign eff_bank = sel_oor ? '0 : bank_sel;

  for (genvar r = 0; r < RADIX; r++) begin : g_lane
    logic [NUM_BANK*P_WIDTH-1:0] lane_bus;

    for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
      assign lane_bus[b*P_WIDTH +: P_WIDTH] = bank_data[lane_off(b, r, RADIX, P_WIDTH) +: P_WIDTH];
    end

`ifdef TWI_LANE0_ONE_EN
    if (r == 0) begin : g_one
      logic unused_lane0;
      assign unused_lane0                 = ^lane_bus;
      assign sel_data[0 +: P_WIDTH]       = P_WIDTH'(1);
    end else begin : g_mux
      twi_lane_sel #(
        .P_WIDTH (P_WIDTH),
        .NUM_BANK(NUM_BANK),
        .BSEL_W  (BSEL_W)
      ) u_sel (
        .lane_bus (lane_bus),
        .bank_sel (bank_sel),
        .lane_data(sel_data[r*P_WIDTH +: P_WIDTH])
      );
    end
`else
    twi_lane_sel #(
      .P_WIDTH (P_WIDTH),
      .NUM_BANK(NUM_BANK),
      .BSEL_W  (BSEL_W)
    ) u_sel (
      .lane_bus (lane_bus),
      .bank_sel (bank_sel),
      .lane_data(sel_data[r*P_WIDTH +: P_WIDTH])
    );
`endif
  end

  // A simultaneous accept wins over a drain so the stage sustains one beat per cycle.
  always_comb begin
    state_d = state_q;
    if (load)      state_d = FULL;
    else if (xfer) state_d = EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      // NOTE: wide data registers normally skip reset; this one is cleared because a zero output in reset is part of the interface.
      twi_data <= '0;
      twi_bank <= '0;
      sel_err  <= 1'b0;
      xfer_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      if (load) begin
        twi_data <= sel_data;
        twi_bank <= eff_bank;
      end
      if (clr) begin
        sel_err  <= 1'b0;
        xfer_cnt <= '0;
      end else begin
        if (load && sel_oor) sel_err <= 1'b1;
        if (xfer)            xfer_cnt <= xfer_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/twi_bank_mux_pipe.md
Name: twi_bank_mux_pipe

Overview:
- Parametrised, registered successor to the two-bank combinational twiddle-factor mux in the radix-16 NTT datapath.
- Each accepted transfer selects one of NUM_BANK twiddle banks, each RADIX lanes of P_WIDTH bits, and presents it to the butterfly multipliers.
- The output is registered behind a valid/ready handshake.
- Tracks out-of-range bank selects and counts completed transfers.

Parameters:
- P_WIDTH, 64, width of one twiddle word.
- RADIX, 16, lanes per bank.
- NUM_BANK, 2, number of twiddle banks (>=2).
- BSEL_W, $clog2(NUM_BANK), width of bank select.
- CNT_W, 16, transfer counter width.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  bank_data/bank_sel valid.
- in_ready  output  1  block can accept this cycle.
- bank_sel  input  BSEL_W  bank index (replaces BN_wire).
- bank_data  input  NUM_BANK*RADIX*P_WIDTH  flattened banks; bank b lane r at bits [(b*RADIX+r)*P_WIDTH +: P_WIDTH].
- out_valid  output  1  twi_data valid.
- out_ready  input  1  consumer accepts.
- twi_data  output  RADIX*P_WIDTH  selected lanes; lane r at [r*P_WIDTH +: P_WIDTH].
- twi_bank  output  BSEL_W  bank index actually used for twi_data.
- sel_err  output  1  sticky: an out-of-range bank_sel was accepted.
- xfer_cnt  output  CNT_W  count of completed output transfers.
- clr  input  1  synchronous clear of sel_err and xfer_cnt.

Behaviour:
- Reset (rst_n low, async):
  - out_valid=0, twi_data=0, twi_bank=0, sel_err=0, xfer_cnt=0.
  - in_ready reflects the reset state (1).
- Single output register stage; latency 1 cycle from accept to out_valid.
- in_ready = !out_valid || out_ready (combinational, no combinational path from in_valid).
- Accept when in_valid && in_ready:
  - Next cycle out_valid=1.
  - twi_data = selected bank's lanes.
  - twi_bank = effective index.
- Output transfer when out_valid && out_ready.
  - With no simultaneous accept, out_valid drops to 0 next cycle.
  - With a simultaneous accept, the register reloads and out_valid stays 1 (full throughput, one transfer per cycle).
- Hold: while out_valid && !out_ready, twi_data and twi_bank are stable; in_ready=0.
- Out-of-range select (bank_sel >= NUM_BANK; only possible when NUM_BANK is not a power of 2):
  - Bank 0 is used and twi_bank=0.
  - sel_err sets on the accept cycle and stays set until clr or reset.
- xfer_cnt increments by 1 per output transfer and wraps from 2^CNT_W-1 to 0.
- clr:
  - Forces sel_err=0 and xfer_cnt=0 next cycle.
  - clr takes priority over a same-cycle increment or error set.
  - clr does not affect the data path or out_valid.
- bank_data is sampled only on accept; changes at other times are ignored.
- Reset mid-operation: the pending output is discarded and out_valid returns to 0 immediately (async).
- No state machine beyond the valid bit; states are EMPTY (out_valid=0) and FULL (out_valid=1).

Optional Feature:
- Macro: TWI_LANE0_ONE_EN.
- Defined: twi_data lane 0 is forced to constant 1 (w^0, zero-extended to P_WIDTH) regardless of bank; lane-0 inputs are unused; all other behaviour is unchanged.
- Undefined: lane 0 is muxed like every other lane.

Decomposition:
- Shared package twi_pkg:
  - Default P_WIDTH, RADIX, NUM_BANK.
  - Lane-slice helper function (bank, lane) -> bit offset.
  - A twiddle-word typedef logic [P_WIDTH-1:0].
- One natural sub-module: twi_lane_sel, combinational NUM_BANK:1 select of one lane with out-of-range fallback, instantiated RADIX times by generate.
- Handshake register and counters stay in the top.

Test Plan:
- Basic select, NUM_BANK=2, out_ready=1:
  - Stimulus: bank b lane r = 16'hB000+b*256+r; accept with bank_sel=1.
  - Response: one cycle later out_valid=1, lane 5 = 0xB105, twi_bank=1; xfer_cnt=1 after transfer.
- Back-pressure:
  - Stimulus: hold out_ready=0 for 3 cycles after accept with bank_sel=0, then present a new input.
  - Response: in_ready=0 throughout, twi_data stable; the new input is accepted the cycle out_ready rises, giving back-to-back transfers.
- Throughput:
  - Stimulus: in_valid=1 and out_ready=1 for 10 cycles with alternating bank_sel.
  - Response: 10 consecutive out_valid beats alternating banks; xfer_cnt=10.
- Out-of-range, NUM_BANK=3:
  - Stimulus: accept bank_sel=3.
  - Response: bank 0 data output, twi_bank=0, sel_err=1 persists; clr pulse clears sel_err and xfer_cnt to 0.
- Reset mid-flight:
  - Stimulus: drop rst_n while out_valid=1.
  - Response: out_valid=0 and xfer_cnt=0 immediately.
- TWI_LANE0_ONE_EN defined:
  - Stimulus: any bank select.
  - Response: lane 0 = 1, lanes 1..15 follow the selected bank.
